// File: rtl/alu_nibble_sequencer_if.sv
// Host-side bundle for alu_nibble_sequencer: start/operand request in,
// busy/done status and the assembled wide result out.
interface alu_nibble_sequencer_if #(
  parameter int NIBBLES = 4
);
  logic                   start;
  logic [4*NIBBLES-1:0]   op_a;
  logic [4*NIBBLES-1:0]   op_b;
  logic [3:0]             op_s;
  logic                   op_m;
  logic                   op_cn;
  logic                   busy;
  logic                   done;
  logic [4*NIBBLES-1:0]   result;
  logic                   cout;
  logic                   eq;

  modport master (
    output start, op_a, op_b, op_s, op_m, op_cn,
    input  busy, done, result, cout, eq
  );

  modport slave (
    input  start, op_a, op_b, op_s, op_m, op_cn,
    output busy, done, result, cout, eq
  );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Time-multiplexes one 74181 slice over NIBBLES nibbles, LSB first; done pulses NIBBLES+1 cycles after accept.
// start is only taken in IDLE; requests while busy or done are dropped, nothing is queued.
module alu_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_nibble_sequencer_if.slave host,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [3:0]           alu_s,
  output logic                 alu_m,
  output logic                 alu_cn,
  input  logic [3:0]           alu_f,
  input  logic                 alu_cn4,
  input  logic                 alu_eq
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [NIBBLES-1:0][3:0] op_a_q, op_b_q, result_q;
  logic [3:0]              op_s_q;
  logic                    op_m_q;
  logic                    carry_q;
  logic                    eq_acc_q;
  logic                    cout_q;
  logic                    eq_q;
  logic [IW-1:0]           idx_q;
  logic                    accept;
  logic                    last;

  assign last = (idx_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    host.busy = 1'b0;
    host.done = 1'b0;
    case (state_q)
      IDLE: begin
        if (host.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        host.busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        host.done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The carry register is left alone on the final nibble so alu_cn keeps
  // showing the last value driven to the slice while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_s_q   <= '0;
      op_m_q   <= 1'b0;
      carry_q  <= 1'b0;
      eq_acc_q <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      eq_q     <= 1'b0;
    end else if (accept) begin
      op_a_q   <= host.op_a;
      op_b_q   <= host.op_b;
      op_s_q   <= host.op_s;
      op_m_q   <= host.op_m;
      carry_q  <= host.op_cn;
      eq_acc_q <= 1'b1;
      idx_q    <= '0;
    end else if (state_q == RUN) begin
      result_q[idx_q] <= alu_f;
      eq_acc_q        <= eq_acc_q & alu_eq;
      if (last) begin
        cout_q <= alu_cn4;
        eq_q   <= eq_acc_q & alu_eq;
      end else begin
        idx_q   <= idx_q + 1'b1;
        carry_q <= alu_cn4;
      end
    end
  end

  assign alu_a       = op_a_q[idx_q];
  assign alu_b       = op_b_q[idx_q];
  assign alu_s       = op_s_q;
  assign alu_m       = op_m_q;
  assign alu_cn      = carry_q;
  assign host.result = result_q;
  assign host.cout   = cout_q;
  assign host.eq     = eq_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: a behavioural 74181 slice on the alu_* side,
// directed and random operations checked against a whole-word arithmetic model.
module tb_alu_nibble_sequencer;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] alu_a, alu_b, alu_s, alu_f;
  logic alu_m, alu_cn, alu_cn4, alu_eq;

  int n_checks = 0;
  int n_err    = 0;

  alu_nibble_sequencer_if #(.NIBBLES(N)) host ();

  alu_nibble_sequencer #(.NIBBLES(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .host    (host),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_s   (alu_s),
    .alu_m   (alu_m),
    .alu_cn  (alu_cn),
    .alu_f   (alu_f),
    .alu_cn4 (alu_cn4),
    .alu_eq  (alu_eq)
  );

  always #5 clk = ~clk;

  // 74181 with active-high data: F = T1 + T2 + carry (arith) or ~(T1 ^ T2) (logic);
  // carries are active low, A=B is high when F is all ones.
  function automatic logic [5:0] slice181(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] s, input logic m, input logic cn);
    logic [3:0] t1, t2, f;
    logic [4:0] sum;
    t1  = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    t2  = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    sum = {1'b0, t1} + {1'b0, t2} + {4'b0, ~cn};
    f   = m ? ~(t1 ^ t2) : sum[3:0];
    return {~sum[4], &f, f};
  endfunction

  assign {alu_cn4, alu_eq, alu_f} = slice181(alu_a, alu_b, alu_s, alu_m, alu_cn);

  // Whole-word reference: one wide addition gives result, cout and every nibble carry-in.
  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] s, input logic m, input logic cn,
                                 output logic [W-1:0] f, output logic co, output logic e,
                                 output logic [N-1:0] cns);
    logic [W-1:0] t1, t2, mask;
    logic [W:0]   sum, part;
    t1  = a | (b & {W{s[0]}}) | (~b & {W{s[1]}});
    t2  = (a & ~b & {W{s[2]}}) | (a & b & {W{s[3]}});
    sum = {1'b0, t1} + {1'b0, t2} + {{W{1'b0}}, ~cn};
    f   = m ? ~(t1 ^ t2) : sum[W-1:0];
    co  = ~sum[W];
    e   = &f;
    for (int k = 0; k < N; k++) begin
      mask   = (W'(1) << (4 * k)) - W'(1);
      part   = {1'b0, t1 & mask} + {1'b0, t2 & mask} + {{W{1'b0}}, ~cn};
      cns[k] = ~part[4 * k];
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] s, input logic m, input logic cn);
    host.op_a  = a;
    host.op_b  = b;
    host.op_s  = s;
    host.op_m  = m;
    host.op_cn = cn;
  endtask

  // Starts from a negedge in IDLE; returns at the negedge after the done cycle.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] s, input logic m, input logic cn,
                        output logic [W-1:0] res, output logic co, output logic e,
                        output logic [N-1:0] cn_seen);
    logic [W-1:0] ef;
    logic         eco, ee;
    logic [N-1:0] ecn;
    int           busy_cnt;
    bit           got_done;
    ref_op(a, b, s, m, cn, ef, eco, ee, ecn);
    busy_cnt = 0;
    got_done = 1'b0;
    cn_seen  = '0;
    chk({tag, "_idle_busy"}, host.busy, 1'b0);
    host.start = 1'b1;
    drive_op(a, b, s, m, cn);
    @(posedge clk);
    for (int c = 0; c < 3 * N + 4 && !got_done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        host.start = 1'b0;
        drive_op(W'($urandom), W'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      end
      if (host.done) got_done = 1'b1;
      else if (host.busy && busy_cnt < N) begin
        cn_seen[busy_cnt] = alu_cn;
        busy_cnt++;
      end
    end
    res = host.result;
    co  = host.cout;
    e   = host.eq;
    chk({tag, "_done_seen"}, got_done, 1'b1);
    chk({tag, "_run_cycles"}, busy_cnt, N);
    chk({tag, "_busy_at_done"}, host.busy, 1'b0);
    chk({tag, "_result"}, res, ef);
    chk({tag, "_cout"}, co, eco);
    chk({tag, "_eq"}, e, ee);
    chk({tag, "_cn_seq"}, cn_seen, ecn);
    @(negedge clk);
    chk({tag, "_done_pulse"}, host.done, 1'b0);
    chk({tag, "_result_held"}, host.result, ef);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] r, ef;
    logic         co, e, eco, ee;
    logic [N-1:0] cs, ecn;
    int           dones[$];
    int           seen;

    host.start = 1'b0;
    drive_op('0, '0, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_busy", host.busy, 1'b0);
    chk("rst_done", host.done, 1'b0);
    chk("rst_result", host.result, '0);
    chk("rst_cout", host.cout, 1'b0);
    chk("rst_eq", host.eq, 1'b0);
    chk("rst_alu_ab", {alu_a, alu_b}, 8'h00);
    chk("rst_alu_smcn", {alu_s, alu_m, alu_cn}, 6'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_start", host.busy, 1'b0);

    run_op("add", 16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b1, r, co, e, cs);
    chk("add_const", r, 16'h2345);
    chk("add_cout_const", co, 1'b1);

    run_op("ripple", 16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, r, co, e, cs);
    chk("ripple_const", r, 16'h0000);
    chk("ripple_cout_const", co, 1'b0);
    chk("ripple_cn_const", cs, 4'b0001);

    run_op("cmp_eq", 16'h5A5A, 16'h5A5A, 4'b0110, 1'b0, 1'b1, r, co, e, cs);
    chk("cmp_eq_const", {r, e}, {16'hFFFF, 1'b1});
    run_op("cmp_ne", 16'h5A5A, 16'h5A5B, 4'b0110, 1'b0, 1'b1, r, co, e, cs);
    chk("cmp_ne_const", e, 1'b0);

    run_op("xor", 16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, r, co, e, cs);
    chk("xor_const", r, 16'h0FF0);

    // Reset partway through RUN: abort with no done pulse.
    host.start = 1'b1;
    drive_op(16'h1234, 16'h4321, 4'b1001, 1'b0, 1'b1);
    @(negedge clk);
    host.start = 1'b0;
    @(negedge clk);
    chk("mid_busy_before", host.busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", host.busy, 1'b0);
    chk("mid_rst_done", host.done, 1'b0);
    chk("mid_rst_result", host.result, '0);
    chk("mid_rst_alu", {alu_a, alu_b, alu_s, alu_m, alu_cn}, 14'h0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (host.done || host.busy) seen++;
    end
    chk("mid_rst_quiet", seen, 0);
    run_op("after_rst", 16'hABCD, 16'h0F0F, 4'b1001, 1'b0, 1'b0, r, co, e, cs);

    // start held high: one accept every N+2 cycles, each with the right result.
    ref_op(16'h0FF1, 16'h7007, 4'b1001, 1'b0, 1'b1, ef, eco, ee, ecn);
    host.start = 1'b1;
    drive_op(16'h0FF1, 16'h7007, 4'b1001, 1'b0, 1'b1);
    for (int c = 0; c < 40 && dones.size() < 3; c++) begin
      @(negedge clk);
      if (host.done) begin
        dones.push_back(c);
        chk("held_result", host.result, ef);
      end
    end
    host.start = 1'b0;
    chk("held_dones", dones.size(), 3);
    if (dones.size() == 3) begin
      chk("held_period1", dones[1] - dones[0], N + 2);
      chk("held_period2", dones[2] - dones[1], N + 2);
    end
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      run_op("rand", ra, rb, 4'($urandom), 1'($urandom), 1'($urandom), r, co, e, cs);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
